// File: rtl/axis_image_feeder_pkg.sv
// Shared network constants and image feeder FSM encoding.
// Build option: AXIS_FEEDER_TIMEOUT_EN enables the result watchdog.
package axis_image_feeder_pkg;

  localparam int dataWidth       = 16;
  localparam int numWeightLayer1 = 784;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_WAIT
  } feeder_state_t;

endpackage

// File: rtl/axis_image_feeder_pixel_buffer.sv
// Simple dual-port pixel RAM: one write port,
// one registered read port with read enable.
module pixel_buffer
  import axis_image_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = dataWidth,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  s_axi_aclk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge s_axi_aclk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register resets; contents survive reset.
  always_ff @(posedge s_axi_aclk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_image_feeder.sv
// AXI-Stream image feeder: streams a buffered frame, then captures the result.
// Build option: AXIS_FEEDER_TIMEOUT_EN adds a sticky result watchdog.
module axis_image_feeder
  import axis_image_feeder_pkg::*;
#(
  parameter int DATA_WIDTH     = dataWidth,
  parameter int FRAME_LEN      = numWeightLayer1,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  s_axi_aclk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  input  logic                  nn_intr,
  input  logic [31:0]           nn_result,
  output logic [31:0]           result,
  output logic                  result_valid,
  output logic [15:0]           frame_count,
  output logic                  timeout_err
);

  localparam logic [ADDR_WIDTH:0] FRAME_END =
    (ADDR_WIDTH+1)'(FRAME_LEN);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(FRAME_LEN-1);

  if (FRAME_LEN > 2**ADDR_WIDTH || TIMEOUT_CYCLES < 1)
  begin : g_bad_cfg
    $error("axis_image_feeder: bad parameters");
  end

  feeder_state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] raddr;
  logic xfer, at_last, buf_we, buf_re, tmo_hit;

  assign xfer    = (state == S_STREAM) && m_axis_ready;
  assign at_last = (idx == LAST_IDX);
  assign buf_we  = wr_en && (state == S_IDLE) &&
                   ({1'b0, wr_addr} < FRAME_END);
  assign buf_re  = (state == S_PRIME) || (xfer && !at_last);
  assign raddr   = (state == S_PRIME) ? '0 : idx + 1'b1;

  pixel_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_buf (
    .s_axi_aclk(s_axi_aclk),
    .reset     (reset),
    .we        (buf_we),
    .waddr     (wr_addr),
    .wdata     (wr_data),
    .re        (buf_re),
    .raddr     (raddr),
    .rdata     (m_axis_data)
  );

  assign busy         = (state != S_IDLE);
  assign m_axis_valid = (state == S_STREAM);
  assign m_axis_last  = m_axis_valid && at_last;

  always_ff @(posedge s_axi_aclk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_PRIME;
      S_PRIME:  state_nxt = S_STREAM;
      S_STREAM: if (xfer && at_last) state_nxt = S_WAIT;
      S_WAIT:   if (nn_intr || tmo_hit) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      idx          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      frame_count  <= '0;
    end else begin
      result_valid <= 1'b0;
      done         <= 1'b0;
      if (state == S_IDLE && start)
        idx <= '0;
      else if (xfer && !at_last)
        idx <= idx + 1'b1;
      if (state == S_WAIT && nn_intr) begin
        result       <= nn_result;
        result_valid <= 1'b1;
        done         <= 1'b1;
        frame_count  <= frame_count + 1'b1;
      end else if (tmo_hit) begin
        done <= 1'b1;
      end
    end
  end

`ifdef AXIS_FEEDER_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_err_q;

  assign tmo_hit = (state == S_WAIT) && !nn_intr &&
                   (tmo_cnt == 32'(TIMEOUT_CYCLES-1));
  assign timeout_err = tmo_err_q;

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state != S_WAIT) tmo_cnt <= '0;
      else                 tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) tmo_err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/axis_image_feeder.md
# axis_image_feeder

Transmit-side AXI-Stream master that holds one input image in a local pixel buffer and streams it into the network's `axis_in_data` slave port, one pixel per beat. After the last pixel it waits for the network's interrupt, captures the classification result, and returns to idle. It sits between the test/host loader and the network top level, and is the stimulus counterpart of the network's stream receiver.

## Interface

**Parameters**
- `DATA_WIDTH`, default `dataWidth` (16): pixel width in bits.
- `FRAME_LEN`, default `numWeightLayer1` (784): pixels per image.
- `ADDR_WIDTH`, default 10: buffer address width; must satisfy 2^ADDR_WIDTH ≥ FRAME_LEN.
- `TIMEOUT_CYCLES`, default 65535: watchdog limit, used only with the macro enabled.

**Ports** (clock and reset first)
- `s_axi_aclk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: pixel buffer write strobe.
- `wr_addr` in ADDR_WIDTH: buffer write address.
- `wr_data` in DATA_WIDTH: pixel value.
- `start` in 1: single-cycle request to stream the buffer.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse when the result is captured.
- `m_axis_data` out DATA_WIDTH: stream pixel.
- `m_axis_valid` out 1: stream valid.
- `m_axis_ready` in 1: stream ready from the network.
- `m_axis_last` out 1: high on the final beat.
- `nn_intr` in 1: network output-valid interrupt.
- `nn_result` in 32: network max-index output.
- `result` out 32: latched classification.
- `result_valid` out 1: one-cycle pulse with `result` update.
- `frame_count` out 16: completed frames; wraps at 0xFFFF→0.
- `timeout_err` out 1: sticky error flag (macro only; tied 0 otherwise).

## Operation

- **States:** IDLE, PRIME, STREAM, WAIT_RESULT.
- **IDLE:**
  - `wr_en` writes `wr_data` to `buf[wr_addr]`. Addresses ≥ FRAME_LEN are ignored.
  - `start` moves to PRIME, resets the pixel index to 0 and issues a read of `buf[0]`.
  - `nn_intr` is ignored.
- **PRIME:** one cycle, then STREAM with `m_axis_valid`=1 and `m_axis_data`=`buf[0]`.
- **STREAM:**
  - A beat transfers when `m_axis_valid && m_axis_ready`.
  - On each transfer the index increments and `buf[index+1]` is read.
  - While `valid && !ready`, data and last are held stable.
  - `m_axis_last` = (index == FRAME_LEN-1).
  - A transfer with last high deasserts valid on the next cycle and moves to WAIT_RESULT.
- **WAIT_RESULT:** on `nn_intr`, `result`←`nn_result`, `result_valid` and `done` pulse, `frame_count` increments, and the state returns to IDLE.
- **Ignored inputs:** `start` outside IDLE; `wr_en` outside IDLE (the buffer is frozen while busy).
- **Reset, including mid-frame:**
  - State returns to IDLE; index, valid, last, done, result_valid and frame_count go to 0; `result` goes to 0; timeout_err is cleared.
  - Buffer contents are not cleared.
- **Reset values of all outputs are 0.**

## Timing

- `start` at cycle T gives `m_axis_valid`=1 at T+2.
- With `m_axis_ready` held high, FRAME_LEN beats occur in FRAME_LEN consecutive cycles, with no bubbles.
- Buffer read latency is 1 cycle. The read is enabled only on a transfer, or in PRIME, so the RAM output holds during stalls.
- `nn_intr` at cycle N gives `result`, `result_valid` and `done` at N+1. `busy` is 0 at N+1.
- `start` is accepted in the cycle `busy` falls, so back-to-back frames are possible.
- Write and start asserted in the same IDLE cycle: the write completes, and streaming reads the new value.

## Configuration

- **`AXIS_FEEDER_TIMEOUT_EN` defined:**
  - A counter runs in WAIT_RESULT.
  - If `nn_intr` is absent for TIMEOUT_CYCLES cycles, `timeout_err` is set (sticky until reset), `done` pulses, `result_valid` stays 0, `frame_count` is unchanged, and the state returns to IDLE.
- **Undefined:** WAIT_RESULT waits indefinitely; `timeout_err` is constant 0; no counter is synthesized.

## Structure

- `dataWidth`, `numWeightLayer1` and the state encodings belong in the shared include/package, alongside the existing layer constants.
- One sub-module: `pixel_buffer`, a simple dual-port RAM with DATA_WIDTH × 2^ADDR_WIDTH, one write port, and a 1-cycle registered read with read enable.
- FSM, index counter and result capture live in the top module.

## Test plan

- **Ramp frame:** load `buf[i]`=i for i=0..783, pulse start, hold ready=1 → 784 beats with data 0..783, last only on beat 783, and first valid 2 cycles after start.
- **Backpressure:** ready toggles 1,0,0,1 repeatedly → every beat's data is held during stalls, no pixel is dropped or duplicated, and the sequence is still 0..783.
- **Result capture:** after the last beat, drive `nn_intr` with `nn_result`=7 → `result`=7, single-cycle `result_valid`/`done`, `frame_count`=1, busy=0.
- **Illegal requests:** start and wr_en (addr 5, data 0xFFFF) asserted mid-STREAM → ignored; `buf[5]` still 5 on the next frame.
- **Mid-frame reset:** reset at beat 300 → valid=0 and busy=0 in the following cycle, `frame_count`=0; a new start replays from pixel 0 with the buffer intact.
- **Timeout (macro on, TIMEOUT_CYCLES=100):** no `nn_intr` → `timeout_err`=1 and `done` pulse after 100 cycles in WAIT_RESULT, `result_valid` never asserted.
